fixed_div_responder: RTL

//  Signed fixed-point divider (Q-format, z = a / b) that implements the responder end of the

---
 rtl/fixed_div_responder_pkg.sv | 27 ++
 rtl/fixed_div_responder_step.sv | 28 ++
 rtl/fixed_div_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fixed_div_responder_pkg.sv
// Shared definitions for the fixed-point divider responder.
// Holds the FSM state encoding, default widths, and the handshake latency helper.
// The latency helper is used by benches and by the solver's timeout logic.
package fixed_div_responder_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FRAC_BITS  = 16;

  typedef enum logic [2:0] {
    ST_GET_AB  = 3'd0,
    ST_PREP    = 3'd1,
    ST_DIVIDE  = 3'd2,
    ST_FINISH  = 3'd3,
    ST_PUT_Z   = 3'd4
  } div_state_t;

  // Edges from the accepting edge to output_z_stb rising (non-zero divisor).
  function automatic int div_latency(input int data_width, input int frac_bits);
    return data_width + frac_bits + 2;
  endfunction

  // Edges from the accepting edge to output_z_stb rising for a zero divisor.
  function automatic int div_latency_dbz();
    return 2;
  endfunction

endpackage

// File: rtl/fixed_div_responder_step.sv
// Purpose: one restoring-division iteration (shift in a dividend bit, trial subtract).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to register it.
// Ports: rem_in (current remainder), bit_in (next dividend bit), divisor,
//        rem_out (updated remainder), q_bit (quotient bit for this step).
module fixed_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_in,
  input  logic                  bit_in,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   rem_out,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted_lo;

  always_comb begin
    // The shifted value is DATA_WIDTH+2 bits wide; its top bit is rem_in's MSB.
    // If that bit is set the shifted value certainly exceeds the divisor, and the
    // true difference still fits in DATA_WIDTH+1 bits, so modular subtraction on
    // the low bits gives the exact result.
    shifted_lo = {rem_in[DATA_WIDTH-1:0], bit_in};
    q_bit      = rem_in[DATA_WIDTH] || (shifted_lo >= {1'b0, divisor});
    rem_out    = q_bit ? (shifted_lo - {1'b0, divisor}) : shifted_lo;
  end

endmodule

// File: rtl/fixed_div_responder.sv
// Purpose: signed Q-format divider z = a / b, responder side of the stb/ack handshake.
// Latency: DATA_WIDTH+FRAC_BITS+2 edges accept-to-output_z_stb, 2 edges for b == 0.
// Backpressure: result and flags held while output_z_ack is low; new operands refused until taken.
// Ports: i_clk/i_rst (sync, active-high); input_a/input_b/input_stb/input_ack operand handshake;
//        output_z/output_z_stb/output_z_ack result handshake; o_div_by_zero/o_overflow valid with z.
module fixed_div_responder
  import fixed_div_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] input_a,
  input  logic [DATA_WIDTH-1:0] input_b,
  input  logic                  input_stb,
  output logic                  input_ack,
  output logic [DATA_WIDTH-1:0] output_z,
  output logic                  output_z_stb,
  input  logic                  output_z_ack,
  output logic                  o_div_by_zero,
  output logic                  o_overflow
);

  localparam int N     = DATA_WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(N);

  localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  // Quotient magnitude limits: 2^(W-1)-1 for positive results, 2^(W-1) for negative.
  localparam logic [N-1:0] LIM_POS = {{FRAC_BITS{1'b0}}, SAT_POS};
  localparam logic [N-1:0] LIM_NEG = {{FRAC_BITS{1'b0}}, SAT_NEG};

  div_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic                  sign;
  logic [DATA_WIDTH-1:0] abs_b;
  logic [N-1:0]          dividend;
  logic [DATA_WIDTH:0]   rem;
  logic [N-1:0]          quot;
  logic [CNT_W-1:0]      cnt;

  logic [DATA_WIDTH:0]   step_rem;
  logic                  step_q;

  logic [DATA_WIDTH-1:0] abs_a;
  logic [N-1:0]          quot_limit;

  // Two's-complement negation of the most negative value yields 2^(W-1),
  // which is exactly the unsigned magnitude wanted.
  assign abs_a      = a_reg[DATA_WIDTH-1] ? -a_reg : a_reg;
  assign quot_limit = sign ? LIM_NEG : LIM_POS;

  // Dividend is consumed MSB-first by shifting, equivalent to indexing bit cnt.
  fixed_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem_in  (rem),
    .bit_in  (dividend[N-1]),
    .divisor (abs_b),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_GET_AB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_GET_AB: if (input_stb && input_ack) state_nxt = ST_PREP;
      ST_PREP:   state_nxt = (b_reg == '0) ? ST_FINISH : ST_DIVIDE;
      ST_DIVIDE: if (cnt == '0) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_PUT_Z;
      ST_PUT_Z:  if (output_z_stb && output_z_ack) state_nxt = ST_GET_AB;
      default:   state_nxt = ST_GET_AB;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      input_ack     <= 1'b1;
      output_z_stb  <= 1'b0;
      output_z      <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      sign          <= 1'b0;
      abs_b         <= '0;
      dividend      <= '0;
      rem           <= '0;
      quot          <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        ST_GET_AB: begin
          if (input_stb && input_ack) begin
            a_reg         <= input_a;
            b_reg         <= input_b;
            input_ack     <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
          end
        end
        ST_PREP: begin
          sign     <= a_reg[DATA_WIDTH-1] ^ b_reg[DATA_WIDTH-1];
          abs_b    <= b_reg[DATA_WIDTH-1] ? -b_reg : b_reg;
          dividend <= {abs_a, {FRAC_BITS{1'b0}}};
          rem      <= '0;
          quot     <= '0;
          cnt      <= CNT_W'(N - 1);
        end
        ST_DIVIDE: begin
          rem      <= step_rem;
          quot     <= {quot[N-2:0], step_q};
          dividend <= {dividend[N-2:0], 1'b0};
          cnt      <= cnt - CNT_W'(1);
        end
        ST_FINISH: begin
          if (b_reg == '0) begin
            // 0/0 takes the positive saturation value.
            output_z      <= a_reg[DATA_WIDTH-1] ? SAT_NEG : SAT_POS;
            o_div_by_zero <= 1'b1;
          end else if (quot > quot_limit) begin
            output_z   <= sign ? SAT_NEG : SAT_POS;
            o_overflow <= 1'b1;
          end else begin
            output_z <= sign ? -quot[DATA_WIDTH-1:0] : quot[DATA_WIDTH-1:0];
          end
          output_z_stb <= 1'b1;
        end
        ST_PUT_Z: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            input_ack    <= 1'b1;
          end
        end
        default: begin
          input_ack    <= 1'b1;
          output_z_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule
